// File: rtl/logic_unit_pkg.sv
// Shared op codes, FSM states and helpers for the slice-serial logic unit.
// Optional popcount output is enabled with LOGIC_UNIT_POPCOUNT_EN.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_ANDN = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/logic_unit_if.sv
// Handshake and data bus of the logic unit; popcnt exists only with LOGIC_UNIT_POPCOUNT_EN.
interface logic_unit_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;

`ifdef LOGIC_UNIT_POPCOUNT_EN
  logic [logic_unit_pkg::clog2(WIDTH + 1)-1:0] popcnt;

  modport master (output in_valid, a, b, op, out_ready,
                  input  in_ready, out_valid, y, zero, parity, popcnt);
  modport slave  (input  in_valid, a, b, op, out_ready,
                  output in_ready, out_valid, y, zero, parity, popcnt);
`else
  modport master (output in_valid, a, b, op, out_ready,
                  input  in_ready, out_valid, y, zero, parity);
  modport slave  (input  in_valid, a, b, op, out_ready,
                  output in_ready, out_valid, y, zero, parity);
`endif

endinterface

// File: rtl/logic_slice.sv
// Combinational bitwise operation on one SLICE-bit slice of the operands.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] y_s
);

  always_comb begin
    y_s = '0;
    case (op)
      OP_AND:  y_s = a_s & b_s;
      OP_OR:   y_s = a_s | b_s;
      OP_XOR:  y_s = a_s ^ b_s;
      OP_XNOR: y_s = ~(a_s ^ b_s);
      OP_NAND: y_s = ~(a_s & b_s);
      OP_NOR:  y_s = ~(a_s | b_s);
      OP_NOTA: y_s = ~a_s;
      OP_ANDN: y_s = a_s & ~b_s;
      default: y_s = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Slice-serial bitwise logic unit: WIDTH-bit ops computed SLICE bits per clock with zero/parity flags.
// Defining LOGIC_UNIT_POPCOUNT_EN adds an accumulated popcount output.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic         clk,
  input logic         rst,
  logic_unit_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (clog2(NSLICE) < 1) ? 1 : clog2(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] y_r;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt;
  logic             nz_acc;
  logic             par_acc;
  logic             zero_r;
  logic             parity_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] y_s;

  // The counter selects which slice of the captured operands feeds the single slice unit.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        a_s = a_r[k*SLICE +: SLICE];
        b_s = b_r[k*SLICE +: SLICE];
      end
    end
  end

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a_s (a_s),
    .b_s (b_s),
    .op  (op_r),
    .y_s (y_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= OP_AND;
      y_r         <= '0;
      cnt         <= '0;
      nz_acc      <= 1'b0;
      par_acc     <= 1'b0;
      zero_r      <= 1'b0;
      parity_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            op_r       <= bus.op;
            y_r        <= '0;
            cnt        <= '0;
            nz_acc     <= 1'b0;
            par_acc    <= 1'b0;
            zero_r     <= 1'b0;
            parity_r   <= 1'b0;
            in_ready_r <= 1'b0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (cnt == CW'(k)) y_r[k*SLICE +: SLICE] <= y_s;
          end
          nz_acc  <= nz_acc | (|y_s);
          par_acc <= par_acc ^ (^y_s);
          // Flags are finalised from the accumulators plus the last slice on the same edge.
          if (cnt == LAST) begin
            zero_r      <= ~(nz_acc | (|y_s));
            parity_r    <= par_acc ^ (^y_s);
            out_valid_r <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOGIC_UNIT_POPCOUNT_EN
  localparam int PW = clog2(WIDTH + 1);
  logic [PW-1:0] pop_acc;
  logic [PW-1:0] pop_s;

  always_comb begin
    pop_s = '0;
    for (int i = 0; i < SLICE; i++) pop_s = pop_s + PW'(y_s[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 pop_acc <= '0;
    else if (state == ST_IDLE && bus.in_valid) pop_acc <= '0;
    else if (state == ST_BUSY)               pop_acc <= pop_acc + pop_s;
  end

  assign bus.popcnt = pop_acc;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = y_r;
  assign bus.zero      = zero_r;
  assign bus.parity    = parity_r;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq at SLICE=1, 8 and 32 against a whole-word reference model.
// Popcount checks are included when LOGIC_UNIT_POPCOUNT_EN is defined.
module tb_logic_unit_seq;
  import logic_unit_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  // Index 0: SLICE=1, index 1: SLICE=8, index 2: SLICE=32.
  int          nsl [3] = '{32, 4, 1};
  logic        in_valid_d [3];
  logic        out_ready_d [3];
  logic [31:0] a_d [3];
  logic [31:0] b_d [3];
  logic [2:0]  op_d [3];
  logic        ir_w [3];
  logic        ov_w [3];
  logic [31:0] y_w [3];
  logic        z_w [3];
  logic        p_w [3];
`ifdef LOGIC_UNIT_POPCOUNT_EN
  logic [5:0]  pop_w [3];
`endif

  logic        pending [3];
  logic        prev_ov [3];
  int          acc_cyc [3];
  logic [31:0] exp_y [3];

  logic_unit_if #(.WIDTH(32)) bus_s1 ();
  logic_unit_if #(.WIDTH(32)) bus_s8 ();
  logic_unit_if #(.WIDTH(32)) bus_s32 ();

  logic_unit_seq #(.WIDTH(32), .SLICE(1))  dut_s1  (.clk(clk), .rst(rst), .bus(bus_s1));
  logic_unit_seq #(.WIDTH(32), .SLICE(8))  dut_s8  (.clk(clk), .rst(rst), .bus(bus_s8));
  logic_unit_seq #(.WIDTH(32), .SLICE(32)) dut_s32 (.clk(clk), .rst(rst), .bus(bus_s32));

  assign bus_s1.in_valid   = in_valid_d[0];
  assign bus_s1.out_ready  = out_ready_d[0];
  assign bus_s1.a          = a_d[0];
  assign bus_s1.b          = b_d[0];
  assign bus_s1.op         = op_d[0];
  assign bus_s8.in_valid   = in_valid_d[1];
  assign bus_s8.out_ready  = out_ready_d[1];
  assign bus_s8.a          = a_d[1];
  assign bus_s8.b          = b_d[1];
  assign bus_s8.op         = op_d[1];
  assign bus_s32.in_valid  = in_valid_d[2];
  assign bus_s32.out_ready = out_ready_d[2];
  assign bus_s32.a         = a_d[2];
  assign bus_s32.b         = b_d[2];
  assign bus_s32.op        = op_d[2];

  assign ir_w[0] = bus_s1.in_ready;
  assign ov_w[0] = bus_s1.out_valid;
  assign y_w[0]  = bus_s1.y;
  assign z_w[0]  = bus_s1.zero;
  assign p_w[0]  = bus_s1.parity;
  assign ir_w[1] = bus_s8.in_ready;
  assign ov_w[1] = bus_s8.out_valid;
  assign y_w[1]  = bus_s8.y;
  assign z_w[1]  = bus_s8.zero;
  assign p_w[1]  = bus_s8.parity;
  assign ir_w[2] = bus_s32.in_ready;
  assign ov_w[2] = bus_s32.out_valid;
  assign y_w[2]  = bus_s32.y;
  assign z_w[2]  = bus_s32.zero;
  assign p_w[2]  = bus_s32.parity;
`ifdef LOGIC_UNIT_POPCOUNT_EN
  assign pop_w[0] = bus_s1.popcnt;
  assign pop_w[1] = bus_s8.popcnt;
  assign pop_w[2] = bus_s32.popcnt;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refOp(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    case (o)
      3'd0:    return av & bv;
      3'd1:    return av | bv;
      3'd2:    return av ^ bv;
      3'd3:    return ~(av ^ bv);
      3'd4:    return ~(av & bv);
      3'd5:    return ~(av | bv);
      3'd6:    return ~av;
      default: return av & ~bv;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: expected result is computed whole-word at accept and compared while out_valid is high.
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        pending[d] = 1'b0;
        prev_ov[d] = 1'b0;
      end else begin
        if (ov_w[d]) begin
          checkOutput($sformatf("mon_pending[%0d]", d), 64'(pending[d]), 64'd1);
          if (!prev_ov[d])
            checkOutput($sformatf("mon_latency[%0d]", d), 64'(cyc - acc_cyc[d]), 64'(nsl[d]));
          checkOutput($sformatf("mon_y[%0d]", d), 64'(y_w[d]), 64'(exp_y[d]));
          checkOutput($sformatf("mon_zero[%0d]", d), 64'(z_w[d]), 64'(exp_y[d] == 32'd0));
          checkOutput($sformatf("mon_parity[%0d]", d), 64'(p_w[d]), 64'(^exp_y[d]));
`ifdef LOGIC_UNIT_POPCOUNT_EN
          checkOutput($sformatf("mon_popcnt[%0d]", d), 64'(pop_w[d]), 64'($countones(exp_y[d])));
`endif
          checkOutput($sformatf("mon_in_ready_done[%0d]", d), 64'(ir_w[d]), 64'd0);
          if (out_ready_d[d]) pending[d] = 1'b0;
        end
        if (in_valid_d[d] && ir_w[d]) begin
          exp_y[d]   = refOp(op_d[d], a_d[d], b_d[d]);
          pending[d] = 1'b1;
          acc_cyc[d] = cyc + 1;
        end
        prev_ov[d] = ov_w[d];
      end
    end
  end

  task automatic applyStimulus(input int d, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    int n;
    a_d[d]        = av;
    b_d[d]        = bv;
    op_d[d]       = o;
    in_valid_d[d] = 1'b1;
    n = 0;
    while (!ir_w[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir_w[d]) checkOutput("accept_timeout", 64'(ir_w[d]), 64'd1);
    @(posedge clk); #1;
    in_valid_d[d] = 1'b0;
  endtask

  task automatic waitResult(input int d, output int lat);
    lat = 0;
    while (!ov_w[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov_w[d]) checkOutput("result_timeout", 64'(ov_w[d]), 64'd1);
  endtask

  task automatic drainResult(input int d);
    out_ready_d[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_d[d] = 1'b0;
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid_d[d]  = 1'b0;
      out_ready_d[d] = 1'b0;
      a_d[d]         = '0;
      b_d[d]         = '0;
      op_d[d]        = '0;
      pending[d]     = 1'b0;
      prev_ov[d]     = 1'b0;
      acc_cyc[d]     = 0;
      exp_y[d]       = '0;
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("rst_in_ready[%0d]", d), 64'(ir_w[d]), 64'd1);
      checkOutput($sformatf("rst_out_valid[%0d]", d), 64'(ov_w[d]), 64'd0);
    end
    checkOutput("rst_y", 64'(y_w[1]), 64'd0);
    checkOutput("rst_zero", 64'(z_w[1]), 64'd0);
    checkOutput("rst_parity", 64'(p_w[1]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1, OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F);
    waitResult(1, lat);
    checkOutput("xor_latency", 64'(lat), 64'd4);
    checkOutput("xor_y", 64'(y_w[1]), 64'hF0F00F0F);
    checkOutput("xor_zero", 64'(z_w[1]), 64'd0);
    checkOutput("xor_parity", 64'(p_w[1]), 64'd0);
    drainResult(1);

    applyStimulus(1, OP_XOR, 32'hDEADBEEF, 32'hDEADBEEF);
    waitResult(1, lat);
    checkOutput("xor_self_y", 64'(y_w[1]), 64'h0);
    checkOutput("xor_self_zero", 64'(z_w[1]), 64'd1);
    checkOutput("xor_self_parity", 64'(p_w[1]), 64'd0);
    drainResult(1);

    applyStimulus(1, OP_NOTA, 32'h00000001, 32'hFFFFFFFF);
    waitResult(1, lat);
    checkOutput("nota_y", 64'(y_w[1]), 64'hFFFFFFFE);
    checkOutput("nota_parity", 64'(p_w[1]), 64'd1);
`ifdef LOGIC_UNIT_POPCOUNT_EN
    checkOutput("nota_popcnt", 64'(pop_w[1]), 64'd31);
`endif
    drainResult(1);

    // Hold the result under backpressure while the input bus churns.
    applyStimulus(1, OP_ANDN, 32'h12345678, 32'h0000FFFF);
    waitResult(1, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid_d[1] = i[0];
      a_d[1]        = $urandom;
      b_d[1]        = $urandom;
      op_d[1]       = 3'(i);
      @(posedge clk); #1;
      checkOutput("bp_y", 64'(y_w[1]), 64'h12340000);
      checkOutput("bp_out_valid", 64'(ov_w[1]), 64'd1);
      checkOutput("bp_in_ready", 64'(ir_w[1]), 64'd0);
    end
    in_valid_d[1] = 1'b0;
    drainResult(1);
    checkOutput("bp_release_in_ready", 64'(ir_w[1]), 64'd1);
    checkOutput("bp_release_out_valid", 64'(ov_w[1]), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("bp_no_second_accept", 64'(ov_w[1]), 64'd0);
    end

    // Abandon an ANDN after two slices have been written.
    applyStimulus(1, OP_ANDN, 32'hFFFFFFFF, 32'h00000000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("partial_y", 64'(y_w[1]), 64'h0000FFFF);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(ov_w[1]), 64'd0);
    checkOutput("midrst_y", 64'(y_w[1]), 64'd0);
    checkOutput("midrst_in_ready", 64'(ir_w[1]), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_done", 64'(ov_w[1]), 64'd0);
    end

    for (int d = 0; d < 3; d++) begin
      for (int o = 0; o < 8; o++) begin
        applyStimulus(d, 3'(o), $urandom, $urandom);
        waitResult(d, lat);
        checkOutput($sformatf("sweep_latency[%0d][%0d]", d, o), 64'(lat), 64'(nsl[d]));
        drainResult(d);
      end
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
